// File: rtl/dport_pkg.sv
// Shared types and constants for the DisplayPort pixel converter slice.
package dport_pkg;

  localparam int PAL_DEPTH = 16;

  typedef logic [23:0] color_t;

  localparam color_t DARK   = 24'h002100;
  localparam color_t BRIGHT = 24'h00F000;

  typedef enum logic [1:0] {
    BPP1 = 2'd0,
    BPP2 = 2'd1,
    BPP4 = 2'd2
  } bpp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LPAD,
    S_ACT,
    S_RPAD
  } state_e;

  // Code 3 is unused and falls back to 1bpp.
  function automatic bpp_e decode_bpp(input logic [1:0] m);
    case (m)
      2'd1:    decode_bpp = BPP2;
      2'd2:    decode_bpp = BPP4;
      default: decode_bpp = BPP1;
    endcase
  endfunction

endpackage

// File: rtl/dport_pxconv_pal_if.sv
// Raw framebuffer stream in, pixel beat stream out.
interface dport_pxconv_pal_if #(
  parameter int IN_W = 16,
  parameter int PPC  = 2
);
  logic              raw_pixel_valid;
  logic [IN_W-1:0]   raw_pixel_data;
  logic              raw_pixel_ready;
  logic              dp_pixel_valid;
  logic [PPC*24-1:0] dp_pixel_data;
  logic              dp_pixel_ready;

  // Environment side: DMA source and transmitter sink.
  modport master (
    output raw_pixel_valid, raw_pixel_data, dp_pixel_ready,
    input  raw_pixel_ready, dp_pixel_valid, dp_pixel_data
  );

  // Converter side.
  modport slave (
    input  raw_pixel_valid, raw_pixel_data, dp_pixel_ready,
    output raw_pixel_ready, dp_pixel_valid, dp_pixel_data
  );
endinterface

// File: rtl/dport_palette.sv
// 16-entry colour palette: one write port, PPC combinational read ports.
module dport_palette
  import dport_pkg::*;
#(
  parameter int PPC = 2
) (
  input  logic                 dpclk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  color_t               wdata,
  input  logic [PPC-1:0][3:0]  raddr,
  output color_t [PPC-1:0]     rdata
);

  color_t mem [PAL_DEPTH];

  // Write port; reset restores the two-colour default map.
  always_ff @(posedge dpclk) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++)
        mem[i] <= (i == 0) ? DARK : (i == 1) ? BRIGHT : '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < PPC; k++) begin : g_rd
    assign rdata[k] = mem[raddr[k]];
  end

endmodule

// File: rtl/dport_pxconv_pal.sv
// Palette pixel converter: packed 1/2/4 bpp words -> PPC RGB pixels per beat,
// framed as left pad / active / right pad per line.
module dport_pxconv_pal
  import dport_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int PPC  = 2,
  parameter int XW   = 16
) (
  input  logic           dpclk,
  input  logic           reset,
  dport_pxconv_pal_if.slave px,
  input  logic           dpdmahstart,
  input  logic [1:0]     cfg_bpp,
  input  logic [XW-1:0]  cfg_pad,
  input  logic [XW-1:0]  cfg_width,
  input  color_t         cfg_padcol,
  input  logic           pal_we,
  input  logic [3:0]     pal_addr,
  input  color_t         pal_data,
  output logic           underflow,
  input  logic           underflow_clr
);

  localparam int CW = $clog2(IN_W + 1);

  state_e            state;
  logic [XW-1:0]     x, pad_q, width_q;
  bpp_e              bpp_q;
  color_t            padcol_q;
  logic [IN_W-1:0]   sr;
  logic [CW-1:0]     cnt, need;
  logic              out_valid;
  logic [PPC*24-1:0] out_data, beat_data;
  logic              slot, have, beat, consume, accept, uf_set;
  logic [XW+1:0]     x_nx, pad_end, act_end, line_end;
  logic [PPC-1:0][3:0] idx;
  color_t [PPC-1:0]  pal_rd;

  // Bits consumed per active beat.
  always_comb begin
    need = CW'(PPC);
    case (bpp_q)
      BPP2:    need = CW'(PPC * 2);
      BPP4:    need = CW'(PPC * 4);
      default: need = CW'(PPC);
    endcase
  end

  assign slot = !out_valid || px.dp_pixel_ready;
  assign have = cnt >= need;

  // Beat generation; a line start preempts whatever the old line would emit.
  always_comb begin
    beat = 1'b0;
    case (state)
      S_LPAD, S_RPAD: beat = slot;
      S_ACT:          beat = slot && have;
      default:        beat = 1'b0;
    endcase
    if (dpdmahstart) beat = 1'b0;
  end

  assign consume = beat && (state == S_ACT);
  assign px.raw_pixel_ready = reset || (cnt == '0) || (cnt == need && consume);
  assign accept  = px.raw_pixel_valid && px.raw_pixel_ready;
  assign uf_set  = (dpdmahstart && state != S_IDLE) ||
                   (!dpdmahstart && state == S_ACT && slot && !have);

  assign x_nx     = {2'b00, x} + (XW+2)'(PPC);
  assign pad_end  = {2'b00, pad_q};
  assign act_end  = pad_end + {2'b00, width_q};
  assign line_end = act_end + {2'b00, pad_q};

  // Per-pixel palette index: bpp-bit field from the top of the word, zero-extended.
  always_comb begin
    idx = '0;
    for (int k = 0; k < PPC; k++) begin
      case (bpp_q)
        BPP2:    idx[k] = {2'b00, sr[IN_W-1-2*k -: 2]};
        BPP4:    idx[k] = sr[IN_W-1-4*k -: 4];
        default: idx[k] = {3'b000, sr[IN_W-1-k]};
      endcase
    end
  end

  dport_palette #(.PPC(PPC)) u_pal (
    .dpclk (dpclk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (idx),
    .rdata (pal_rd)
  );

  // Beat payload: palette colours in ACT, pad colour otherwise; pixel 0 lowest.
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < PPC; k++)
      beat_data[24*k +: 24] = (state == S_ACT) ? pal_rd[k] : padcol_q;
  end

  // Shift register: a new word wins over flush and consume (it replaces the
  // last fragment or belongs to the line being started).
  always_ff @(posedge dpclk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= px.raw_pixel_data;
      cnt <= CW'(IN_W);
    end else if (dpdmahstart) begin
      cnt <= '0;
    end else if (consume) begin
      sr  <= sr << need;
      cnt <= cnt - need;
    end
  end

  // Line FSM with the output beat register and sticky underflow.
  always_ff @(posedge dpclk) begin
    if (reset) begin
      state     <= S_IDLE;
      x         <= '0;
      pad_q     <= '0;
      width_q   <= '0;
      bpp_q     <= BPP1;
      padcol_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      underflow <= 1'b0;
    end else begin
      if (beat) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
      end else if (px.dp_pixel_ready) begin
        out_valid <= 1'b0;
      end

      if (uf_set)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;

      if (dpdmahstart) begin
        bpp_q    <= decode_bpp(cfg_bpp);
        pad_q    <= cfg_pad;
        width_q  <= cfg_width;
        padcol_q <= cfg_padcol;
        x        <= '0;
        // An all-empty line has nothing to emit.
        if (cfg_pad != '0)        state <= S_LPAD;
        else if (cfg_width != '0) state <= S_ACT;
        else                      state <= S_IDLE;
      end else if (beat) begin
        x <= x + XW'(PPC);
        case (state)
          S_LPAD: if (x_nx == pad_end)  state <= (width_q != '0) ? S_ACT : S_RPAD;
          S_ACT:  if (x_nx == act_end)  state <= (pad_q != '0) ? S_RPAD : S_IDLE;
          S_RPAD: if (x_nx == line_end) state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign px.dp_pixel_valid = out_valid;
  assign px.dp_pixel_data  = out_data;

endmodule

// File: tb/tb_dport_pxconv_pal.sv
// Scoreboard bench: stimulus queues expected beats from a pixel-list model,
// a monitor pops and compares on every output handshake.
module tb_dport_pxconv_pal;

  logic        dpclk, reset;
  logic        dpdmahstart, pal_we, underflow, underflow_clr;
  logic [1:0]  cfg_bpp;
  logic [15:0] cfg_pad, cfg_width;
  logic [23:0] cfg_padcol, pal_data;
  logic [3:0]  pal_addr;

  dport_pxconv_pal_if #(.IN_W(16), .PPC(2)) px ();

  dport_pxconv_pal #(.IN_W(16), .PPC(2), .XW(16)) dut (
    .dpclk(dpclk), .reset(reset), .px(px.slave),
    .dpdmahstart(dpdmahstart), .cfg_bpp(cfg_bpp), .cfg_pad(cfg_pad),
    .cfg_width(cfg_width), .cfg_padcol(cfg_padcol),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  initial dpclk = 1'b0;
  always #5 dpclk = ~dpclk;

  int checks = 0, errors = 0, beats_seen = 0;
  logic [47:0] exp_q[$];
  logic [15:0] raw_q[$], stage[$];
  logic [23:0] pal_m[16];
  bit hold = 0, rand_gap = 0, rand_bp = 0, force_stall = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic cycle();
    @(negedge dpclk);
    px.dp_pixel_ready = force_stall ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic pal_reset_model();
    for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
    pal_m[0] = 24'h002100;
    pal_m[1] = 24'h00F000;
  endtask

  task automatic pal_write(input int a, input logic [23:0] c);
    pal_we = 1'b1; pal_addr = 4'(a); pal_data = c;
    pal_m[a] = c;
    cycle();
    pal_we = 1'b0;
  endtask

  // Expected line: pad beats, active pixels decoded from the word stream
  // (first pixel in the top bits), pad beats. Pixel 0 of a beat in the low half.
  task automatic queue_line(input int mode, input int pad, input int width, input logic [23:0] pc);
    int b, w;
    int pix[$];
    b = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
    foreach (stage[i]) begin
      w = int'(stage[i]);
      for (int j = 0; j < 16 / b; j++)
        pix.push_back((w >> (16 - (j + 1) * b)) & ((1 << b) - 1));
    end
    for (int i = 0; i < pad / 2; i++) exp_q.push_back({pc, pc});
    for (int i = 0; i < width / 2; i++) exp_q.push_back({pal_m[pix[2*i+1]], pal_m[pix[2*i]]});
    for (int i = 0; i < pad / 2; i++) exp_q.push_back({pc, pc});
    foreach (stage[i]) raw_q.push_back(stage[i]);
    stage.delete();
    dpdmahstart = 1'b1; cfg_bpp = 2'(mode); cfg_pad = 16'(pad);
    cfg_width = 16'(width); cfg_padcol = pc; beats_seen = 0;
    cycle();
    dpdmahstart = 1'b0;
  endtask

  task automatic wait_line(input int nb, input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin cycle(); t++; end
    if (t >= 20000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
    end
    repeat (6) cycle();
    chk(name, 64'(beats_seen), 64'(nb));
    exp_q.delete();
  endtask

  task automatic clr_underflow();
    underflow_clr = 1'b1; cycle(); underflow_clr = 1'b0; cycle();
    chk("underflow_clr", 64'(underflow), 64'd0);
  endtask

  // Raw word driver: offers the queue head, pops on handshake.
  initial forever begin
    @(negedge dpclk); #1;
    if (raw_q.size() > 0 && !hold && !(rand_gap && $urandom_range(0, 3) == 0)) begin
      px.raw_pixel_valid = 1'b1;
      px.raw_pixel_data  = raw_q[0];
    end else begin
      px.raw_pixel_valid = 1'b0;
    end
    #1;
    if (!reset && px.raw_pixel_valid && px.raw_pixel_ready) void'(raw_q.pop_front());
  end

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  logic        stalled = 1'b0;
  logic [47:0] held = '0;
  initial forever begin
    @(negedge dpclk); #2;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && px.dp_pixel_valid) chk("stall_hold", 64'(px.dp_pixel_data), 64'(held));
      if (px.dp_pixel_valid && px.dp_pixel_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected none", px.dp_pixel_data);
        end else begin
          chk("beat", 64'(px.dp_pixel_data), 64'(exp_q.pop_front()));
        end
      end
      stalled = px.dp_pixel_valid && !px.dp_pixel_ready;
      held    = px.dp_pixel_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, nw, mode, pad, width;
    reset = 1'b1; dpdmahstart = 1'b0; pal_we = 1'b0; underflow_clr = 1'b0;
    cfg_bpp = '0; cfg_pad = '0; cfg_width = '0; cfg_padcol = '0;
    pal_addr = '0; pal_data = '0;
    px.raw_pixel_valid = 1'b0; px.raw_pixel_data = '0; px.dp_pixel_ready = 1'b1;
    pal_reset_model();

    // Reset state
    repeat (3) cycle();
    #1;
    chk("rst_ready", 64'(px.raw_pixel_ready), 64'd1);
    chk("rst_valid", 64'(px.dp_pixel_valid), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    cycle(); reset = 1'b0;
    repeat (2) cycle();
    chk("idle_valid", 64'(px.dp_pixel_valid), 64'd0);

    // 1bpp default palette, long line
    for (int i = 0; i < 50; i++) stage.push_back(16'hAAAA);
    queue_line(0, 240, 800, 24'h123456);
    wait_line(640, "lineA_beats");
    chk("lineA_underflow", 64'(underflow), 64'd0);

    // 2bpp, no pad
    pal_write(0, 24'h111111); pal_write(1, 24'h222222);
    pal_write(2, 24'h333333); pal_write(3, 24'h444444);
    stage.push_back(16'h1B1B);
    queue_line(1, 0, 8, 24'h0);
    wait_line(4, "lineB_beats");

    // 4bpp, ready reasserts while the second beat is generated
    pal_write(15, 24'hABCDEF);
    stage.push_back(16'hF0E1);
    queue_line(2, 0, 4, 24'h0);
    #1; chk("c_ready_busy", 64'(px.raw_pixel_ready), 64'd0);
    cycle(); #1;
    chk("c_ready_back", 64'(px.raw_pixel_ready), 64'd1);
    chk("c_first_valid", 64'(px.dp_pixel_valid), 64'd1);
    wait_line(2, "lineC_beats");

    // Randomized lines with backpressure and raw gaps
    rand_bp = 1; rand_gap = 1;
    for (int n = 0; n < 12; n++) begin
      for (int p = 0; p < 3; p++) pal_write($urandom_range(0, 15), 24'($urandom));
      mode = $urandom_range(0, 3);
      pad = 2 * $urandom_range(0, 10);
      width = 2 * $urandom_range(1, 32);
      nw = (width * ((mode == 1) ? 2 : (mode == 2) ? 4 : 1) + 15) / 16;
      for (int i = 0; i < nw; i++) stage.push_back(16'($urandom));
      queue_line(mode, pad, width, 24'($urandom));
      wait_line(pad + width / 2, "rand_beats");
    end
    rand_bp = 0; rand_gap = 0;
    cycle();

    // Backpressure mid-active
    clr_underflow();
    for (int i = 0; i < 4; i++) stage.push_back(16'($urandom));
    queue_line(0, 8, 64, 24'h0F0F0F);
    t = 0;
    while (beats_seen < 8 && t < 200) begin cycle(); t++; end
    force_stall = 1; repeat (5) cycle(); force_stall = 0;
    wait_line(40, "bp_beats");
    chk("bp_underflow", 64'(underflow), 64'd0);

    // Starvation in ACT
    hold = 1;
    for (int i = 0; i < 4; i++) stage.push_back(16'($urandom));
    queue_line(0, 8, 64, 24'h00AA00);
    repeat (10) cycle();
    hold = 0;
    wait_line(40, "starve_beats");
    chk("starve_underflow", 64'(underflow), 64'd1);
    clr_underflow();

    // Abort mid-active after 150 beats, restart with new cfg
    for (int i = 0; i < 50; i++) stage.push_back(16'($urandom));
    queue_line(0, 240, 800, 24'h777777);
    t = 0;
    while (beats_seen < 150 && t < 1000) begin cycle(); t++; end
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    raw_q.delete();
    for (int i = 0; i < 2; i++) stage.push_back(16'($urandom));
    queue_line(1, 4, 16, 24'h550055);
    wait_line(13, "abort_beats");
    chk("abort_underflow", 64'(underflow), 64'd1);

    // Reset mid-ACT
    for (int i = 0; i < 13; i++) stage.push_back(16'($urandom));
    queue_line(0, 4, 200, 24'h333333);
    t = 0;
    while (beats_seen < 10 && t < 200) begin cycle(); t++; end
    reset = 1'b1; exp_q.delete(); raw_q.delete();
    cycle(); #1;
    chk("mid_rst_valid", 64'(px.dp_pixel_valid), 64'd0);
    chk("mid_rst_ready", 64'(px.raw_pixel_ready), 64'd1);
    cycle(); reset = 1'b0;
    pal_reset_model();
    beats_seen = 0;
    repeat (10) cycle();
    chk("post_rst_valid", 64'(px.dp_pixel_valid), 64'd0);
    chk("post_rst_underflow", 64'(underflow), 64'd0);
    chk("post_rst_beats", 64'(beats_seen), 64'd0);

    // Palette defaults restored by reset
    for (int i = 0; i < 2; i++) stage.push_back(16'($urandom));
    queue_line(2, 2, 8, 24'h010203);
    wait_line(6, "post_rst_line");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
